// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, RUN/HALT control
// and a saturating count of delivered instructions.
module fetch_stage #(
    parameter int unsigned    IW       = 32,
    parameter int unsigned    DW       = 32,
    parameter logic [IW-1:0]  RESET_PC = '0,
    parameter logic [5:0]     HALT_OP  = 6'h3F
) (
    input  logic          clk,
    input  logic          rst,
    output logic [IW-1:0] imem_addr,
    input  logic [DW-1:0] imem_data,
    input  logic          stall_in,
    input  logic          redirect,
    input  logic [IW-1:0] redirect_pc,
    output logic          if_valid,
    output logic [DW-1:0] if_instr,
    output logic [IW-1:0] if_pc,
    output logic          halted,
    output logic [15:0]   fetch_count
);

    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   pc_q, pc_d;
    logic            if_valid_q, if_valid_d;
    logic [DW-1:0]   if_instr_q, if_instr_d;
    logic [IW-1:0]   if_pc_q, if_pc_d;
    logic [CW-1:0]   fetch_count_q, fetch_count_d;
    logic            is_halt_op;

    assign is_halt_op = (imem_data[DW-1:DW-6] == HALT_OP);

    // State register and pipeline flops; reset discards everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_instr_q    <= '0;
            if_pc_q       <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Next state: redirect beats everything; a bubble never blocks an accept.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        fetch_count_d = fetch_count_q;

        if (redirect) begin
            state_d    = ST_RUN;
            pc_d       = redirect_pc;
            if_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!stall_in || !if_valid_q) begin
                        if_instr_d = imem_data;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        if (fetch_count_q != CNT_MAX) begin
                            fetch_count_d = fetch_count_q + CW'(1);
                        end
                        // The halt word is delivered but the PC parks on it.
                        if (is_halt_op) begin
                            state_d = ST_HALT;
                        end else begin
                            pc_d = pc_q + IW'(1);
                        end
                    end
                end
                ST_HALT: begin
                    if (!stall_in) begin
                        if_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    assign imem_addr   = pc_q;
    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign fetch_count = fetch_count_q;
    assign halted      = (state_q == ST_HALT);

endmodule
